// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states and one-hot grants.
package mem_arbiter_pkg;

    // Arbiter phases. DRAIN is the single dead cycle between transactions.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BUSY  = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_e;

    // One-hot grant vectors; bit index is the port number.
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_P0   = 2'b01;
    localparam logic [1:0] GNT_P1   = 2'b10;

endpackage

// File: rtl/arb_rr2.sv
// Combinational 2-way round-robin picker. ptr_i = 0 favours port 0 on contention.
module arb_rr2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] grant_o
);

    // Single requester wins outright; on contention the pointer breaks the tie.
    always_comb begin
        grant_o = GNT_NONE;
        if (req_i == 2'b11)
            grant_o = ptr_i ? GNT_P1 : GNT_P0;
        else if (req_i[0])
            grant_o = GNT_P0;
        else if (req_i[1])
            grant_o = GNT_P1;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one mem_fsm port between the CPU (port 0) and a secondary master
// (port 1). Round-robin, grant held for the whole transaction, one drain
// cycle between transactions so a requester's lingering enable is not
// mistaken for a new request.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_data_in,
    input  logic              p0_read_en,
    input  logic              p0_write_en,
    output logic [DATA_W-1:0] p0_data_out,
    output logic              p0_done,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_data_in,
    input  logic              p1_read_en,
    input  logic              p1_write_en,
    output logic [DATA_W-1:0] p1_data_out,
    output logic              p1_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_read_en,
    output logic              mem_write_en,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_done,
    output logic [1:0]        grant,
    output logic              busy
);

    arb_state_e        state_q;
    logic              ptr_q;
    logic [1:0]        grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rd_q;
    logic              wr_q;

    logic [1:0]        req;
    logic [1:0]        pick;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              win_rd;
    logic              win_wr;
    logic              done_fire;

    assign req = {p1_read_en | p1_write_en, p0_read_en | p0_write_en};

    arb_rr2 u_rr (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (pick)
    );

    // Select the winning port's request fields for capture on the grant edge.
    always_comb begin
        win_addr = p0_addr;
        win_data = p0_data_in;
        win_rd   = p0_read_en;
        win_wr   = p0_write_en;
        if (pick[1]) begin
            win_addr = p1_addr;
            win_data = p1_data_in;
            win_rd   = p1_read_en;
            win_wr   = p1_write_en;
        end
    end

    // Arbiter FSM: capture winner in IDLE, wait for mem_done in BUSY, one DRAIN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= 1'b0;
            grant_q <= GNT_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (|req) begin
                        state_q <= ARB_BUSY;
                        grant_q <= pick;
                        // Only contention moves the pointer: hand the next tie to the loser.
                        if (&req)
                            ptr_q <= pick[0];
                        addr_q  <= win_addr;
                        wdata_q <= win_data;
                        // Read and write together means write.
                        wr_q    <= win_wr;
                        rd_q    <= win_rd & ~win_wr;
                    end
                end
                ARB_BUSY: begin
                    if (mem_done) begin
                        state_q <= ARB_DRAIN;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                    end
                end
                ARB_DRAIN: begin
                    state_q <= ARB_IDLE;
                    grant_q <= GNT_NONE;
                end
                default: begin
                    state_q <= ARB_IDLE;
                    grant_q <= GNT_NONE;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                end
            endcase
        end
    end

    // Completion is only honoured while a transaction is actually outstanding.
    assign done_fire = (state_q == ARB_BUSY) && mem_done;

    assign p0_done     = done_fire & grant_q[0];
    assign p1_done     = done_fire & grant_q[1];
    assign p0_data_out = p0_done ? mem_data_out : '0;
    assign p1_data_out = p1_done ? mem_data_out : '0;

    assign mem_addr     = addr_q;
    assign mem_data_in  = wdata_q;
    assign mem_read_en  = rd_q;
    assign mem_write_en = wr_q;
    assign grant        = grant_q;
    assign busy         = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a small fixed-latency memory model.
module tb_mem_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] p0_addr, p1_addr, mem_addr;
    logic [DW-1:0] p0_data_in, p1_data_in, p0_data_out, p1_data_out;
    logic          p0_read_en, p0_write_en, p1_read_en, p1_write_en;
    logic          p0_done, p1_done;
    logic [DW-1:0] mem_data_in, mem_data_out;
    logic          mem_read_en, mem_write_en, mem_done;
    logic [1:0]    grant;
    logic          busy;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .p0_addr(p0_addr), .p0_data_in(p0_data_in), .p0_read_en(p0_read_en),
        .p0_write_en(p0_write_en), .p0_data_out(p0_data_out), .p0_done(p0_done),
        .p1_addr(p1_addr), .p1_data_in(p1_data_in), .p1_read_en(p1_read_en),
        .p1_write_en(p1_write_en), .p1_data_out(p1_data_out), .p1_done(p1_done),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_read_en(mem_read_en),
        .mem_write_en(mem_write_en), .mem_data_out(mem_data_out), .mem_done(mem_done),
        .grant(grant), .busy(busy)
    );

    // ---------------- memory model ----------------
    logic [DW-1:0] mem [0:255];
    logic          preload, model_en, force_done;
    logic          model_done;
    logic [DW-1:0] model_rdata;
    int            cnt;

    always @(posedge clk) begin
        if (preload) begin
            mem[8'h10]  <= 16'hBEEF;
            mem[8'h30]  <= 16'h1111;
            mem[8'h31]  <= 16'h2222;
            mem[8'h40]  <= 16'h3333;
            mem[8'h41]  <= 16'h4444;
            mem[8'h20]  <= 16'h0000;
            cnt         <= 0;
            model_done  <= 1'b0;
            model_rdata <= '0;
        end else begin
            model_done <= 1'b0;
            if (model_en && (mem_read_en || mem_write_en) && !model_done) begin
                if (cnt == LAT - 1) begin
                    cnt        <= 0;
                    model_done <= 1'b1;
                    if (mem_write_en) begin
                        mem[mem_addr[7:0]] <= mem_data_in;
                        model_rdata        <= '0;
                    end else begin
                        model_rdata <= mem[mem_addr[7:0]];
                    end
                end else begin
                    cnt <= cnt + 1;
                end
            end
        end
    end

    assign mem_done     = model_done | force_done;
    assign mem_data_out = model_done ? model_rdata : '0;

    // ---------------- scoreboard ----------------
    typedef struct {
        int            port;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(int p, logic [DW-1:0] d);
        exp_t e;
        e.port = p;
        e.data = d;
        sb.push_back(e);
    endtask

    // Monitor: every done pulse must match the next expected completion.
    always @(negedge clk) begin
        exp_t e;
        check("grant_not_two_hot", {31'b0, grant == 2'b11}, 0);
        if (p0_done && p1_done) begin
            check("both_done", {p1_done, p0_done}, 2'b00);
        end else if (p0_done || p1_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", {p1_done, p0_done}, 2'b00);
            end else begin
                e = sb.pop_front();
                check("done_port", p1_done ? 1 : 0, e.port);
                check("data_out", p1_done ? p1_data_out : p0_data_out, e.data);
                check("grant_owner", grant, (e.port == 1) ? 2'b10 : 2'b01);
            end
        end else begin
            check("data_out_idle_zero", {p1_data_out, p0_data_out}, 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int p, bit rd, bit wr, logic [AW-1:0] a, logic [DW-1:0] d);
        if (p == 0) begin
            p0_read_en = rd; p0_write_en = wr; p0_addr = a; p0_data_in = d;
        end else begin
            p1_read_en = rd; p1_write_en = wr; p1_addr = a; p1_data_in = d;
        end
    endtask

    // Returns at the negedge inside the done cycle, or flags a timeout.
    task automatic wait_done(int p, string name);
        bit seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if ((p == 0) ? p0_done : p1_done) seen = 1;
        end
        if (!seen) check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        rst = 1'b1; preload = 1'b1; model_en = 1'b1; force_done = 1'b0;
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        tick();
        preload = 1'b0;
        tick();
        @(negedge clk);
        check("rst_grant", grant, 2'b00);
        check("rst_busy", busy, 0);
        check("rst_mem_en", {mem_read_en, mem_write_en}, 2'b00);
        check("rst_mem_addr", mem_addr, 0);
        rst = 1'b0;

        // Single read by port 0
        tick();
        drive(0, 1, 0, 16'h0010, 16'h0000);
        push(0, 16'hBEEF);
        @(negedge clk);
        check("rd_en_before_grant", mem_read_en, 0);
        @(negedge clk);
        check("rd_en_after_1cyc", mem_read_en, 1);
        check("rd_grant", grant, 2'b01);
        check("rd_busy", busy, 1);
        check("rd_mem_addr", mem_addr, 16'h0010);
        wait_done(0, "single_read");
        tick();
        drive(0, 0, 0, '0, '0);
        @(negedge clk);
        check("drain_busy", busy, 1);
        check("drain_rd_en", mem_read_en, 0);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_grant", grant, 2'b00);

        // Write priority on port 1
        tick();
        drive(1, 1, 1, 16'h0020, 16'h1234);
        push(1, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        check("wp_write_en", mem_write_en, 1);
        check("wp_read_en", mem_read_en, 0);
        check("wp_grant", grant, 2'b10);
        check("wp_data_in", mem_data_in, 16'h1234);
        wait_done(1, "write_prio");
        tick();
        drive(1, 0, 0, '0, '0);
        check("wp_mem_word", mem[8'h20], 16'h1234);
        tick();

        // CPU-style release: enable lingers through DRAIN
        tick();
        drive(0, 1, 0, 16'h0010, 16'h0000);
        push(0, 16'hBEEF);
        wait_done(0, "cpu_release");
        tick();
        tick();
        drive(0, 0, 0, '0, '0);
        @(negedge clk);
        check("rel_idle_busy", busy, 0);
        @(negedge clk);
        check("rel_no_reissue_busy", busy, 0);
        check("rel_no_reissue_en", mem_read_en, 0);
        tick();
        drive(0, 1, 0, 16'h0030, 16'h0000);
        push(0, 16'h1111);
        wait_done(0, "rel_followup");
        tick();
        drive(0, 0, 0, '0, '0);
        tick();

        // Contention from reset: expect p0, p1, p0, p1
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        push(0, 16'h1111);
        push(1, 16'h3333);
        push(0, 16'h2222);
        push(1, 16'h4444);
        fork
            begin
                for (int k = 0; k < 2; k++) begin
                    drive(0, 1, 0, 16'h0030 + 16'(k), 16'h0000);
                    wait_done(0, "cont_p0");
                    tick();
                end
                drive(0, 0, 0, '0, '0);
            end
            begin
                for (int j = 0; j < 2; j++) begin
                    drive(1, 1, 0, 16'h0040 + 16'(j), 16'h0000);
                    wait_done(1, "cont_p1");
                    tick();
                end
                drive(1, 0, 0, '0, '0);
            end
        join
        tick();
        check("cont_sb_drained", sb.size(), 0);

        // Reset mid-transaction; mem_done arrives during and after reset
        model_en = 1'b0;
        tick();
        drive(0, 1, 0, 16'h0040, 16'h0000);
        tick();
        tick();
        check("mid_busy_before_rst", busy, 1);
        rst = 1'b1;
        drive(0, 0, 0, '0, '0);
        tick();
        force_done = 1'b1;
        @(negedge clk);
        check("mid_rst_grant", grant, 2'b00);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_en", {mem_read_en, mem_write_en}, 2'b00);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_wdata", mem_data_in, 0);
        check("mid_rst_done", {p1_done, p0_done}, 2'b00);
        tick();
        rst = 1'b0;
        tick();
        force_done = 1'b0;
        @(negedge clk);
        check("mid_after_busy", busy, 0);
        model_en = 1'b1;
        tick();
        drive(1, 1, 0, 16'h0041, 16'h0000);
        push(1, 16'h4444);
        @(negedge clk);
        @(negedge clk);
        check("mid_next_grant", grant, 2'b10);
        wait_done(1, "mid_next");
        tick();
        drive(1, 0, 0, '0, '0);
        tick();
        tick();

        // Stray mem_done while idle
        force_done = 1'b1;
        @(negedge clk);
        check("stray_done", {p1_done, p0_done}, 2'b00);
        tick();
        force_done = 1'b0;
        @(negedge clk);
        check("stray_busy", busy, 0);
        check("stray_grant", grant, 2'b00);

        tick();
        check("sb_empty_at_end", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
